// File: rtl/aes_iter_core.sv
// aes_iter_core: iterative AES encryptor, one round per clock over a shared datapath
// with the key schedule expanded on the fly one round key at a time.
module aes_iter_core #(
    parameter int KEY_BITS = 128
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [127:0]        data_in,
    input  logic [KEY_BITS-1:0] key,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [127:0]        data_out,
    output logic                busy
);
    localparam int NR = (KEY_BITS == 256) ? 14 : 10;
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_key
        $error("aes_iter_core: KEY_BITS must be 128 or 256");
    end

    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

    state_t              st, st_nx;
    logic [127:0]        s_r, sr, mixed, round_key, expanded, exp_in;
    logic [KEY_BITS-1:0] key_r, key_next;
    logic [3:0]          rc;
    logic [7:0]          rcon;
    logic                rot, accept, last;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // Bytes are column-major: byte (row r, column c) sits at index 4*c + r.
    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127 - 8*(4*c + r) -: 8] = sbox(s[127 - 8*(4*((c + r) % 4) + r) -: 8]);
        return o;
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] w);
        logic [7:0] a0, a1, a2, a3;
        a0 = w[31:24];
        a1 = w[23:16];
        a2 = w[15:8];
        a3 = w[7:0];
        return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    endfunction

    // One key-schedule step: p is the block of words Nk back, t the most recent word.
    function automatic logic [127:0] expand(input logic [127:0] p, input logic [31:0] t,
                                            input logic rw, input logic [7:0] rcv);
        logic [31:0] tmp, w0, w1, w2, w3;
        tmp = rw ? sub_word({t[23:0], t[31:24]}) ^ {rcv, 24'h0} : sub_word(t);
        w0 = p[127:96] ^ tmp;
        w1 = p[95:64] ^ w0;
        w2 = p[63:32] ^ w1;
        w3 = p[31:0] ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // 128-bit keys: key_r holds the previous round key and the current one is derived from it.
    // 256-bit keys: key_r holds {rk[rc-1], rk[rc]}; the lower half is used directly.
    if (KEY_BITS == 128) begin : g_k128
        assign exp_in    = key_r[127:0];
        assign rot       = 1'b1;
        assign round_key = expanded;
        assign key_next  = expanded;
    end else begin : g_k256
        assign exp_in    = key_r[255:128];
        assign rot       = rc[0];
        assign round_key = key_r[127:0];
        assign key_next  = {key_r[127:0], expanded};
    end

    assign expanded  = expand(exp_in, key_r[31:0], rot, rcon);
    assign sr        = sub_shift(s_r);
    assign mixed     = {mix_col(sr[127:96]), mix_col(sr[95:64]), mix_col(sr[63:32]), mix_col(sr[31:0])};
    assign last      = (rc == 4'(NR));
    assign in_ready  = (st == IDLE) || (st == DONE && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (st == DONE);
    assign busy      = (st == ROUND);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) st <= IDLE;
        else        st <= st_nx;
    end

    always_comb begin
        st_nx = st;
        case (st)
            IDLE:    st_nx = accept ? ROUND : IDLE;
            ROUND:   st_nx = last ? DONE : ROUND;
            DONE:    st_nx = accept ? ROUND : (out_ready ? IDLE : DONE);
            default: st_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_r      <= '0;
            key_r    <= '0;
            rc       <= '0;
            rcon     <= '0;
            data_out <= '0;
        end else if (accept) begin
            s_r   <= data_in ^ key[KEY_BITS-1 -: 128];
            key_r <= key;
            rc    <= 4'd1;
            rcon  <= 8'h01;
        end else if (st == ROUND) begin
            s_r   <= last ? sr ^ round_key : mixed ^ round_key;
            key_r <= key_next;
            rc    <= rc + 4'd1;
            if (rot) rcon <= xt(rcon);
            if (last) data_out <= sr ^ round_key;
        end
    end
endmodule
